// File: rtl/mipi_csi_rx_frontend_n.sv
// CSI-2 receive front end: per-lane deskew FIFOs, packet header parse, payload beats with keep, FS/FE/LS/LE sync.
// Optional build macro MIPI_VC_FILTER_EN: only headers whose VC equals VC_SEL are accepted.
module mipi_csi_rx_frontend_n #(
  parameter int         LANES    = 4,
  parameter int         MAX_SKEW = 3,
  parameter logic [1:0] VC_SEL   = 2'd0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [8*LANES-1:0] byte_i,
  input  logic [LANES-1:0]   byte_valid_i,
  output logic [8*LANES-1:0] data_o,
  output logic [LANES-1:0]   data_keep_o,
  output logic               data_valid_o,
  output logic [5:0]         data_type_o,
  output logic [1:0]         vc_o,
  output logic [15:0]        word_count_o,
  output logic               frame_active_o,
  output logic               line_active_o,
  output logic [15:0]        frame_count_o,
  output logic               err_skew_o,
  output logic               err_trunc_o
);
  localparam int DEPTH     = MAX_SKEW + 1;
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int SW        = $clog2(MAX_SKEW + 2);
  localparam int HDR_BEATS = 4 / LANES;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;
  state_t state_q, state_d;

  logic [7:0]         mem [LANES][DEPTH];
  logic [PW-1:0]      wp [LANES];
  logic [PW-1:0]      rp [LANES];
  logic [CW-1:0]      cnt [LANES];
  logic [LANES-1:0]   ne, full, wr_ok, overflow;
  logic               all_ne, any_ne, pop, flush;
  logic [8*LANES-1:0] beat;

  logic [7:0]         hdr_buf [3];
  logic [7:0]         hb [3];
  logic [1:0]         beat_idx_q;
  logic [5:0]         hdr_dt;
  logic [1:0]         hdr_vc;
  logic [15:0]        hdr_wc;
  logic               vc_match, vc_ok, hdr_long;
  logic               skew_wait, skew_err, trunc_err, hdr_pop, hdr_last, pay_pop;
  logic [15:0]        rem_q, take, rem_next;
  logic [SW-1:0]      skew_cnt_q;
  logic [LANES-1:0]   keep;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      ne[j]          = cnt[j] != '0;
      full[j]        = cnt[j] == CW'(DEPTH);
      beat[8*j +: 8] = mem[j][rp[j]];
    end
  end

  assign all_ne = &ne;
  assign any_ne = |ne;
  assign pop    = all_ne;
  // DRAIN keeps every FIFO empty so nothing of an abandoned burst survives.
  assign flush  = (state_q == DRAIN);

  always_comb begin
    wr_ok    = '0;
    overflow = '0;
    for (int j = 0; j < LANES; j++) begin
      wr_ok[j]    = byte_valid_i[j] && (!full[j] || pop);
      overflow[j] = byte_valid_i[j] && full[j] && !pop && !flush;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < LANES; j++)
      if (wr_ok[j] && !flush) mem[j][wp[j]] <= byte_i[8*j +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush) begin
      for (int j = 0; j < LANES; j++) begin
        wp[j]  <= '0;
        rp[j]  <= '0;
        cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < LANES; j++) begin
        if (wr_ok[j]) wp[j] <= inc(wp[j]);
        if (pop)      rp[j] <= inc(rp[j]);
        case ({wr_ok[j], pop})
          2'b10:   cnt[j] <= cnt[j] + CW'(1);
          2'b01:   cnt[j] <= cnt[j] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Header byte k sits in beat k/LANES, lane k%LANES; earlier beats come from hdr_buf.
  always_comb begin
    for (int k = 0; k < 3; k++)
      hb[k] = (beat_idx_q == 2'(k / LANES)) ? beat[8*(k % LANES) +: 8] : hdr_buf[k];
  end

  assign hdr_dt   = hb[0][5:0];
  assign hdr_vc   = hb[0][7:6];
  assign hdr_wc   = {hb[2], hb[1]};
  assign hdr_long = (hdr_dt >= 6'h10) && (hdr_wc != 16'h0);
  assign vc_match = (hdr_vc == VC_SEL);
`ifdef MIPI_VC_FILTER_EN
  assign vc_ok = vc_match;
`else
  // Every VC accepted; VC_SEL stays referenced but has no effect.
  assign vc_ok = 1'b1 | vc_match;
`endif

  always_comb begin
    state_d   = state_q;
    skew_wait = (state_q == IDLE) && any_ne && !all_ne;
    skew_err  = (|overflow) || (skew_wait && (skew_cnt_q == SW'(MAX_SKEW)));
    hdr_pop   = pop && ((state_q == IDLE) || (state_q == HDR));
    hdr_last  = hdr_pop && (beat_idx_q == 2'(HDR_BEATS - 1));
    pay_pop   = pop && (state_q == PAY);
    take      = (rem_q < 16'(LANES)) ? rem_q : 16'(LANES);
    rem_next  = rem_q - take;
    for (int j = 0; j < LANES; j++) keep[j] = rem_q > 16'(j);
    // No aligned beat can form and every lane is idle: the burst is over.
    trunc_err = (state_q == PAY) && !pop && !(|byte_valid_i) && !skew_err;
    if (skew_err) begin
      state_d = DRAIN;
    end else begin
      case (state_q)
        IDLE:  if (hdr_pop) state_d = hdr_last ? ((vc_ok && hdr_long) ? PAY : DRAIN) : HDR;
        HDR: begin
          if (hdr_last)                          state_d = (vc_ok && hdr_long) ? PAY : DRAIN;
          else if (!pop && !(|byte_valid_i))     state_d = DRAIN;
        end
        PAY: begin
          if (pay_pop && (rem_next == 16'h0))    state_d = DRAIN;
          else if (trunc_err)                    state_d = DRAIN;
        end
        DRAIN: if (!(|byte_valid_i)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o         <= '0;
      data_keep_o    <= '0;
      data_valid_o   <= 1'b0;
      data_type_o    <= '0;
      vc_o           <= '0;
      word_count_o   <= '0;
      frame_active_o <= 1'b0;
      line_active_o  <= 1'b0;
      frame_count_o  <= '0;
      err_skew_o     <= 1'b0;
      err_trunc_o    <= 1'b0;
      rem_q          <= '0;
      skew_cnt_q     <= '0;
      beat_idx_q     <= '0;
      for (int k = 0; k < 3; k++) hdr_buf[k] <= '0;
    end else begin
      data_valid_o <= 1'b0;
      err_skew_o   <= skew_err;
      err_trunc_o  <= trunc_err;
      skew_cnt_q   <= (skew_wait && !skew_err) ? skew_cnt_q + SW'(1) : '0;
      if (state_d != HDR)  beat_idx_q <= '0;
      else if (hdr_pop)    beat_idx_q <= beat_idx_q + 2'd1;
      if (hdr_pop) for (int k = 0; k < 3; k++) hdr_buf[k] <= hb[k];
      if (hdr_last && vc_ok) begin
        vc_o        <= hdr_vc;
        data_type_o <= hdr_dt;
        if (hdr_dt >= 6'h10) begin
          word_count_o <= hdr_wc;
          rem_q        <= hdr_wc;
        end else begin
          case (hdr_dt)
            6'h00: begin
              frame_active_o <= 1'b1;
              frame_count_o  <= frame_count_o + 16'd1;
              line_active_o  <= 1'b0;
            end
            6'h01: if (frame_active_o) begin
              frame_active_o <= 1'b0;
              line_active_o  <= 1'b0;
            end
            6'h02: if (frame_active_o) line_active_o <= 1'b1;
            6'h03: line_active_o <= 1'b0;
            default: ;
          endcase
        end
      end
      if (pay_pop) begin
        data_valid_o <= 1'b1;
        data_o       <= beat;
        data_keep_o  <= keep;
        rem_q        <= rem_next;
      end
    end
  end
endmodule

// File: tb/tb_mipi_csi_rx_frontend_n.sv
// Directed bench for mipi_csi_rx_frontend_n: three instances (4, 2 and 1 lanes) driven by one linear sequence.
module tb_mipi_csi_rx_frontend_n;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-lane instance
  logic [31:0] b4 = '0;  logic [3:0] v4 = '0;
  logic [31:0] d4;  logic [3:0] k4;  logic dv4;  logic [5:0] dt4;  logic [1:0] vc4;
  logic [15:0] wc4, fc4;  logic fa4, la4, es4, et4;
  // 2-lane instance
  logic [15:0] b2 = '0;  logic [1:0] v2 = '0;
  logic [15:0] d2;  logic [1:0] k2;  logic dv2;  logic [5:0] dt2;  logic [1:0] vc2;
  logic [15:0] wc2, fc2;  logic fa2, la2, es2, et2;
  // 1-lane instance, VC_SEL=1
  logic [7:0] b1 = '0;  logic [0:0] v1 = '0;
  logic [7:0] d1;  logic [0:0] k1;  logic dv1;  logic [5:0] dt1;  logic [1:0] vc1;
  logic [15:0] wc1, fc1;  logic fa1, la1, es1, et1;

  mipi_csi_rx_frontend_n #(.LANES(4), .MAX_SKEW(3), .VC_SEL(2'd0)) u4 (
    .clk_i(clk), .reset_i(reset), .byte_i(b4), .byte_valid_i(v4), .data_o(d4), .data_keep_o(k4),
    .data_valid_o(dv4), .data_type_o(dt4), .vc_o(vc4), .word_count_o(wc4), .frame_active_o(fa4),
    .line_active_o(la4), .frame_count_o(fc4), .err_skew_o(es4), .err_trunc_o(et4));
  mipi_csi_rx_frontend_n #(.LANES(2), .MAX_SKEW(3), .VC_SEL(2'd0)) u2 (
    .clk_i(clk), .reset_i(reset), .byte_i(b2), .byte_valid_i(v2), .data_o(d2), .data_keep_o(k2),
    .data_valid_o(dv2), .data_type_o(dt2), .vc_o(vc2), .word_count_o(wc2), .frame_active_o(fa2),
    .line_active_o(la2), .frame_count_o(fc2), .err_skew_o(es2), .err_trunc_o(et2));
  mipi_csi_rx_frontend_n #(.LANES(1), .MAX_SKEW(3), .VC_SEL(2'd1)) u1 (
    .clk_i(clk), .reset_i(reset), .byte_i(b1), .byte_valid_i(v1), .data_o(d1), .data_keep_o(k1),
    .data_valid_o(dv1), .data_type_o(dt1), .vc_o(vc1), .word_count_o(wc1), .frame_active_o(fa1),
    .line_active_o(la1), .frame_count_o(fc1), .err_skew_o(es1), .err_trunc_o(et1));

  // Observed beats and pulse counts, sampled on the falling edge
  logic [31:0] q4d[$];  logic [3:0] q4k[$];  logic [31:0] e4d[$];  logic [3:0] e4k[$];
  logic [15:0] q2d[$];  logic [1:0] q2k[$];  logic [15:0] e2d[$];  logic [1:0] e2k[$];
  logic [7:0]  q1d[$];  logic [0:0] q1k[$];  logic [7:0]  e1d[$];  logic [0:0] e1k[$];
  int n_es4 = 0, n_et4 = 0, n_es2 = 0, n_et2 = 0, n_es1 = 0, n_et1 = 0;

  always @(negedge clk) begin
    if (dv4) begin q4d.push_back(d4); q4k.push_back(k4); end
    if (dv2) begin q2d.push_back(d2); q2k.push_back(k2); end
    if (dv1) begin q1d.push_back(d1); q1k.push_back(k1); end
    if (es4) n_es4++;
    if (et4) n_et4++;
    if (es2) n_es2++;
    if (et2) n_et2++;
    if (es1) n_es1++;
    if (et1) n_et1++;
  end

  logic [7:0] pkt [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mk(input logic [7:0] di, input logic [15:0] wc);
    pkt[0] = di;
    pkt[1] = wc[7:0];
    pkt[2] = wc[15:8];
    pkt[3] = 8'($urandom_range(0, 255));
    for (int i = 0; i < int'(wc); i++) pkt[4+i] = 8'(8'h10 + i);
    pkt[4+int'(wc)] = 8'hC0;
    pkt[5+int'(wc)] = 8'hC1;
  endtask

  // Lanes 0..2 start together; lane 3 starts skew cycles later.
  task automatic drive4(input int n, input int skew);
    int nb;
    nb = n / 4;
    for (int c = 0; c < nb + skew; c++) begin
      for (int j = 0; j < 3; j++) begin
        v4[j] = (c < nb);
        b4[8*j +: 8] = (c < nb) ? pkt[c*4+j] : 8'h00;
      end
      v4[3] = (c >= skew) && (c - skew < nb);
      b4[31:24] = v4[3] ? pkt[(c-skew)*4+3] : 8'h00;
      tick();
    end
    v4 = '0;
    b4 = '0;
  endtask

  task automatic drive2(input int n);
    for (int c = 0; c < (n + 1) / 2; c++) begin
      for (int j = 0; j < 2; j++) begin
        v2[j] = (c*2 + j < n);
        b2[8*j +: 8] = (c*2 + j < n) ? pkt[c*2+j] : 8'h00;
      end
      tick();
    end
    v2 = '0;
    b2 = '0;
  endtask

  task automatic drive1(input int n);
    for (int c = 0; c < n; c++) begin
      v1 = 1'b1;
      b1 = pkt[c];
      tick();
    end
    v1 = '0;
    b1 = '0;
  endtask

  task automatic cmp4(input string tag);
    check({tag, "_count"}, q4d.size(), e4d.size());
    for (int i = 0; i < q4d.size() && i < e4d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q4d[i], e4d[i]);
      check($sformatf("%s_keep%0d", tag, i), q4k[i], e4k[i]);
    end
    q4d.delete(); q4k.delete(); e4d.delete(); e4k.delete();
  endtask

  task automatic cmp2(input string tag);
    check({tag, "_count"}, q2d.size(), e2d.size());
    for (int i = 0; i < q2d.size() && i < e2d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q2d[i], e2d[i]);
      check($sformatf("%s_keep%0d", tag, i), q2k[i], e2k[i]);
    end
    q2d.delete(); q2k.delete(); e2d.delete(); e2k.delete();
  endtask

  task automatic cmp1(input string tag);
    check({tag, "_count"}, q1d.size(), e1d.size());
    for (int i = 0; i < q1d.size() && i < e1d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q1d[i], e1d[i]);
      check($sformatf("%s_keep%0d", tag, i), q1k[i], e1k[i]);
    end
    q1d.delete(); q1k.delete(); e1d.delete(); e1k.delete();
  endtask

  int exp_fc;
  logic [1:0] exp_vc;

  initial begin
    // reset state
    reset = 1'b1;
    idle(3);
    check("rst_dv4", dv4, 0);   check("rst_fa4", fa4, 0);   check("rst_fc4", fc4, 0);
    check("rst_d4", d4, 0);     check("rst_k4", k4, 0);     check("rst_wc4", wc4, 0);
    check("rst_fa2", fa2, 0);   check("rst_la1", la1, 0);   check("rst_es4", es4, 0);
    reset = 1'b0;
    idle(2);

    // 4 lanes, zero skew: FS, LS, long, LE, FE
    mk(8'h00, 16'd0);
    drive4(4, 0);
    check("t1_fa_at_pop", fa4, 0);
    tick();
    check("t1_fa_after_pop", fa4, 1);
    check("t1_fc", fc4, 1);
    check("t1_la_fs", la4, 0);
    check("t1_dt_fs", dt4, 6'h00);
    idle(3);
    mk(8'h02, 16'd0);  drive4(4, 0);  idle(3);
    check("t1_la_ls", la4, 1);
    mk(8'h2B, 16'd10); drive4(16, 0); idle(4);
    e4d.push_back(32'h13121110); e4k.push_back(4'hF);
    e4d.push_back(32'h17161514); e4k.push_back(4'hF);
    e4d.push_back(32'hC1C01918); e4k.push_back(4'h3);
    cmp4("t1_long");
    check("t1_wc", wc4, 16'd10);
    check("t1_dt_long", dt4, 6'h2B);
    check("t1_la_long", la4, 1);
    mk(8'h03, 16'd0);  drive4(4, 0);  idle(3);
    check("t1_la_le", la4, 0);
    check("t1_fa_le", fa4, 1);
    mk(8'h01, 16'd0);  drive4(4, 0);  idle(3);
    check("t1_fa_fe", fa4, 0);
    check("t1_fc_end", fc4, 1);
    check("t1_no_skew", n_es4, 0);
    check("t1_no_trunc", n_et4, 0);

    // skew of 3 is absorbed, skew of 4 errors
    mk(8'h2B, 16'd6);  drive4(12, 3); idle(5);
    e4d.push_back(32'h13121110); e4k.push_back(4'hF);
    e4d.push_back(32'hC1C01514); e4k.push_back(4'h3);
    cmp4("t2_skew3");
    check("t2_skew3_err", n_es4, 0);
    mk(8'h2B, 16'd6);  drive4(12, 4); idle(5);
    cmp4("t2_skew4");
    check("t2_skew4_err", n_es4, 1);
    check("t2_skew4_trunc", n_et4, 0);

    // 2 lanes: LS with no frame, then WC=5, then FS must decode cleanly
    mk(8'h02, 16'd0);  drive2(4);  idle(4);
    check("t5_ls_noframe_la", la2, 0);
    check("t5_ls_noframe_dt", dt2, 6'h02);
    mk(8'h2B, 16'd5);  drive2(11); idle(5);
    e2d.push_back(16'h1110); e2k.push_back(2'b11);
    e2d.push_back(16'h1312); e2k.push_back(2'b11);
    e2d.push_back(16'hC014); e2k.push_back(2'b01);
    cmp2("t3_l2");
    check("t3_wc", wc2, 16'd5);
    check("t3_errs", n_es2 + n_et2, 0);
    mk(8'h00, 16'd0);  drive2(4);  idle(4);
    check("t3_fs_fa", fa2, 1);
    check("t3_fs_fc", fc2, 1);
    check("t3_fs_dt", dt2, 6'h00);

    // 1 lane, VC1: truncated long packet, then FS
    mk(8'h6B, 16'd8);  drive1(6);  idle(5);
    e1d.push_back(8'h10); e1k.push_back(1'b1);
    e1d.push_back(8'h11); e1k.push_back(1'b1);
    cmp1("t4_trunc");
    check("t4_trunc_pulse", n_et1, 1);
    check("t4_no_skew", n_es1, 0);
    check("t4_wc", wc1, 16'd8);
    check("t4_vc", vc1, 2'd1);
    mk(8'h40, 16'd0);  drive1(4);  idle(4);
    check("t4_fs_fa", fa1, 1);
    check("t4_fs_fc", fc1, 1);

    // VC filtering on the 1-lane instance (VC_SEL=1)
`ifdef MIPI_VC_FILTER_EN
    exp_fc = 1;  exp_vc = 2'd1;
`else
    exp_fc = 2;  exp_vc = 2'd0;
`endif
    mk(8'h00, 16'd0);  drive1(4);  idle(4);
    check("t6_vc0_fc", fc1, 32'(exp_fc));
    check("t6_vc0_vc", vc1, exp_vc);
    mk(8'h40, 16'd0);  drive1(4);  idle(4);
    check("t6_vc1_fc", fc1, 32'(exp_fc + 1));
    check("t6_vc1_fa", fa1, 1);

    // reset mid-payload on the 4-lane instance
    mk(8'h00, 16'd0);  drive4(4, 0);  idle(3);
    check("t5_pre_fc", fc4, 2);
    mk(8'h2B, 16'd40);
    for (int c = 0; c < 4; c++) begin
      v4 = 4'hF;
      b4 = {pkt[c*4+3], pkt[c*4+2], pkt[c*4+1], pkt[c*4]};
      tick();
    end
    check("t5_in_pay_dv", dv4, 1);
    reset = 1'b1;
    v4 = '0;
    b4 = '0;
    tick();
    check("t5_rst_dv", dv4, 0);   check("t5_rst_d", d4, 0);     check("t5_rst_k", k4, 0);
    check("t5_rst_fa", fa4, 0);   check("t5_rst_la", la4, 0);   check("t5_rst_fc", fc4, 0);
    check("t5_rst_dt", dt4, 0);   check("t5_rst_vc", vc4, 0);   check("t5_rst_wc", wc4, 0);
    check("t5_rst_es", es4, 0);   check("t5_rst_et", et4, 0);
    reset = 1'b0;
    idle(6);
    e4d.push_back(32'h13121110); e4k.push_back(4'hF);
    e4d.push_back(32'h17161514); e4k.push_back(4'hF);
    cmp4("t5_prereset");
    check("t5_post_skew", n_es4, 1);
    check("t5_post_trunc", n_et4, 0);
    check("t5_post_dv", dv4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mipi_csi_rx_frontend_n.md
Name: mipi_csi_rx_frontend_n

Overview:
Parametrised CSI-2 receive front end. Sits between the per-lane byte aligners and the pixel depacker. Deskews 1, 2 or 4 lanes, parses packet headers and emits payload beats with byte-keep. Generates true frame and line sync from FS/FE/LS/LE short packets, where the existing bridge derives fsync from reset.

Parameters:
LANES, 4, number of data lanes; legal values are 1, 2 and 4.
MAX_SKEW, 3, maximum inter-lane arrival skew in clk_i cycles; per-lane FIFO depth is MAX_SKEW+1.
VC_SEL, 0, 2-bit virtual channel accepted when MIPI_VC_FILTER_EN is defined.

Ports:
clk_i  in  1  byte clock; single clock domain.
reset_i  in  1  synchronous, active-high reset.
byte_i  in  8*LANES  byte-aligned lane data; lane j occupies [8j+7:8j].
byte_valid_i  in  LANES  per-lane HS byte valid, from the byte aligner.
data_o  out  8*LANES  payload beat.
data_keep_o  out  LANES  valid-byte mask for data_o; lane 0 is the first byte.
data_valid_o  out  1  payload beat strobe.
data_type_o  out  6  DT of the current or last header.
vc_o  out  2  VC of the current or last header.
word_count_o  out  16  WC of the current long packet.
frame_active_o  out  1  fsync.
line_active_o  out  1  lsync.
frame_count_o  out  16  count of FS packets accepted.
err_skew_o  out  1  one-cycle pulse: skew limit exceeded.
err_trunc_o  out  1  one-cycle pulse: burst ended mid-payload.

Behaviour:
- Reset:
  - All outputs are 0.
  - FIFOs are emptied and the FSM goes to IDLE on the first clk_i edge with reset_i=1.
  - Reset asserted mid-packet abandons the packet with no error pulse.
- Deskew:
  - Lane j writes byte_i[j] into FIFO j on every cycle its byte_valid_i[j]=1.
  - An aligned beat is popped from all FIFOs together on the cycle all FIFOs are non-empty.
  - Skew window: if some lanes have started and the rest are still empty for MAX_SKEW+1 consecutive cycles, err_skew_o pulses and the FSM enters DRAIN.
  - A FIFO write to a full FIFO counts as a skew error and is handled the same way.
- Header bytes: header byte index = beat*LANES + lane. Byte 0 is DI (VC=[7:6], DT=[5:0]), byte 1 is WC[7:0], byte 2 is WC[15:8], byte 3 is ECC, which is ignored.
- FSM:
  - IDLE -> HDR on the first aligned beat.
  - HDR collects 4/LANES beats; LANES=4 means the header is complete in the same beat. On header complete:
    - DT < 0x10: process the short packet (see below), then go to DRAIN.
    - DT >= 0x10 with WC=0: go to DRAIN.
    - DT >= 0x10 with WC>0: load the remaining-byte counter with WC, then go to PAY.
  - PAY, on each aligned beat:
    - data_valid_o=1, data_o = the beat.
    - keep = all ones, or the low (rem) bits when rem < LANES.
    - rem -= min(rem, LANES).
    - When rem reaches 0, go to DRAIN. The trailing CRC bytes are discarded, not checked.
  - PAY -> DRAIN with an err_trunc_o pulse if all byte_valid_i are 0 and the FIFOs are empty while rem > 0.
  - DRAIN: discard all popped beats. Exit to IDLE when all byte_valid_i=0 and all FIFOs are empty, with the FIFOs flushed. Pending bytes must never leak into the next packet.
- Short packets (processed on header-complete):
  - FS (0x00): frame_active_o <= 1, frame_count_o += 1 (wraps 0xFFFF -> 0), line_active_o <= 0. An FS while a frame is active restarts the frame.
  - FE (0x01): frame_active_o <= 0, line_active_o <= 0. An FE with no active frame is ignored.
  - LS (0x02): line_active_o <= 1, only when frame_active_o=1.
  - LE (0x03): line_active_o <= 0.
  - All other short packets are ignored.
- Latency:
  - Popping begins on the cycle after the last-arriving lane's first write.
  - data_o, data_valid_o and all sync/header outputs are registered, appearing 1 cycle after the pop.
- Simultaneity: a skew error and a truncation condition in the same cycle report err_skew_o only.

Optional Feature:
MIPI_VC_FILTER_EN:
- Defined: headers with VC != VC_SEL are fully ignored. No data_valid_o, no sync change, no counter change, no header-output update. The FSM still goes to DRAIN for that burst.
- Undefined: all VCs are accepted and VC_SEL is unused.

Test Plan:
1. LANES=4, zero skew: FS burst, LS, long packet DT=0x2B WC=10, LE, FE -> frame_active_o rises 1 cycle after the FS pop. Long packet gives 3 beats with keep 1111, 1111, 0011. Sync levels follow LS/LE/FE. frame_count_o=1.
2. LANES=4, lane 3 valid 3 cycles after lane 0 (MAX_SKEW=3) -> beats correctly aligned, no error. Skew of 4 cycles -> err_skew_o single pulse, no data_valid_o for that burst.
3. LANES=2, WC=5 -> header spans 2 beats. Payload is 3 beats with keep 11, 11, 01. CRC bytes are dropped.
4. LANES=1, burst stops after 2 of WC=8 payload bytes -> err_trunc_o pulse. FSM returns to IDLE, and the next FS is decoded correctly.
5. LS with no active frame -> line_active_o stays 0. reset_i asserted mid-PAY -> all outputs 0 on the next cycle, no error pulses.
6. With MIPI_VC_FILTER_EN and VC_SEL=1: FS on VC0 -> no change. FS on VC1 -> frame_active_o=1, frame_count_o increments.
